// File: rtl/mem_dp_param.sv
// mem_dp_param: dual-write/dual-read memory with hardware zero-clear after reset,
// write-collision arbitration, 1/2-cycle read latency and selectable read-during-write.
module mem_dp_param #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 4,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1,
   parameter int WR_PRIO    = 0,
   parameter int RDW_MODE   = 0,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_a,
   input  logic [ADDR_W-1:0] wr_addr_a,
   input  logic [DATA_W-1:0] wr_data_a,
   input  logic              wr_en_b,
   input  logic [ADDR_W-1:0] wr_addr_b,
   input  logic [DATA_W-1:0] wr_data_b,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_valid_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_valid_b,
   output logic              init_done,
   output logic              collision,
   output logic [CNT_W-1:0]  collision_cnt
);
   typedef enum logic {CLEAR, READY} state_t;
   localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                coll_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          v1_q, v2_q;
   logic [DATA_W-1:0]   d1_q [2];
   logic [DATA_W-1:0]   d2_q [2];
   logic [DATA_W-1:0]   rd_d [2];
   logic [ADDR_W-1:0]   rd_addr [2];
   logic [1:0]          rd_req;
   logic                ready, wa_ok, wb_ok, coll, wa_com, wb_com;
   assign ready  = state_q == READY;
   assign wa_ok  = ready & wr_en_a & ({1'b0, wr_addr_a} < DEPTH_V);
   assign wb_ok  = ready & wr_en_b & ({1'b0, wr_addr_b} < DEPTH_V);
   assign coll   = wa_ok & wb_ok & (wr_addr_a == wr_addr_b);
   // The losing port of a collision is simply suppressed.
   assign wa_com = wa_ok & ~(coll & (WR_PRIO != 0));
   assign wb_com = wb_ok & ~(coll & (WR_PRIO == 0));
   assign rd_addr[0] = rd_addr_a;
   assign rd_addr[1] = rd_addr_b;
   assign rd_req     = {rd_en_b, rd_en_a} & {2{ready}};
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == CLEAR) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         state_d   = (clr_ptr_q == LAST) ? READY : CLEAR;
      end
   end
   always_comb begin
      for (int i = 0; i < 2; i++)
         rd_d[i] = ({1'b0, rd_addr[i]} >= DEPTH_V)                             ? '0 :
                   ((RDW_MODE != 0) && wb_com && (wr_addr_b == rd_addr[i])) ? wr_data_b :
                   ((RDW_MODE != 0) && wa_com && (wr_addr_a == rd_addr[i])) ? wr_data_a :
                   mem_q[rd_addr[i]];
   end
   always_ff @(posedge clk) begin
      if (!ready) mem_q[clr_ptr_q] <= '0;
      else begin
         if (wa_com) mem_q[wr_addr_a] <= wr_data_a;
         if (wb_com) mem_q[wr_addr_b] <= wr_data_b;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         coll_q    <= 1'b0;
         cnt_q     <= '0;
         v1_q      <= '0;
         v2_q      <= '0;
         for (int i = 0; i < 2; i++) begin
            d1_q[i] <= '0;
            d2_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         coll_q    <= coll;
         cnt_q     <= (coll && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
         v1_q      <= rd_req;
         v2_q      <= v1_q;
         for (int i = 0; i < 2; i++) begin
            d1_q[i] <= rd_req[i] ? rd_d[i] : d1_q[i];
            d2_q[i] <= v1_q[i] ? d1_q[i] : d2_q[i];
         end
      end
   end
   assign rd_valid_a    = (RD_LATENCY == 2) ? v2_q[0] : v1_q[0];
   assign rd_valid_b    = (RD_LATENCY == 2) ? v2_q[1] : v1_q[1];
   assign rd_data_a     = (RD_LATENCY == 2) ? d2_q[0] : d1_q[0];
   assign rd_data_b     = (RD_LATENCY == 2) ? d2_q[1] : d1_q[1];
   assign init_done     = ready;
   assign collision     = coll_q;
   assign collision_cnt = cnt_q;
endmodule

// File: tb/tb_mem_dp_param.sv
// tb_mem_dp_param: directed checks of two mem_dp_param builds sharing one stimulus;
// u0 = defaults, u1 = RD_LATENCY 2, WR_PRIO 1, RDW_MODE 1, CNT_W 2, DEPTH 12.
module tb_mem_dp_param;
   logic       clk = 1'b0;
   logic       rst0_n, rst1_n;
   logic       wea, web, rea, reb;
   logic [3:0] waa, wab, raa, rab;
   logic [7:0] wda, wdb;
   logic [7:0] rda0, rdb0, rda1, rdb1;
   logic       rva0, rvb0, rva1, rvb1, id0, id1, col0, col1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   int         tests = 0;
   int         fails = 0;
   always #5 clk = ~clk;
   mem_dp_param u0 (
      .clk(clk), .rst_n(rst0_n),
      .wr_en_a(wea), .wr_addr_a(waa), .wr_data_a(wda),
      .wr_en_b(web), .wr_addr_b(wab), .wr_data_b(wdb),
      .rd_en_a(rea), .rd_addr_a(raa), .rd_data_a(rda0), .rd_valid_a(rva0),
      .rd_en_b(reb), .rd_addr_b(rab), .rd_data_b(rdb0), .rd_valid_b(rvb0),
      .init_done(id0), .collision(col0), .collision_cnt(cnt0)
   );
   mem_dp_param #(.RD_LATENCY(2), .WR_PRIO(1), .RDW_MODE(1), .CNT_W(2), .DEPTH(12)) u1 (
      .clk(clk), .rst_n(rst1_n),
      .wr_en_a(wea), .wr_addr_a(waa), .wr_data_a(wda),
      .wr_en_b(web), .wr_addr_b(wab), .wr_data_b(wdb),
      .rd_en_a(rea), .rd_addr_a(raa), .rd_data_a(rda1), .rd_valid_a(rva1),
      .rd_en_b(reb), .rd_addr_b(rab), .rd_data_b(rdb1), .rd_valid_b(rvb1),
      .init_done(id1), .collision(col1), .collision_cnt(cnt1)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      wea = 0; web = 0; rea = 0; reb = 0;
      waa = 0; wab = 0; raa = 0; rab = 0; wda = 0; wdb = 0;
   endtask
   task automatic test_reset;
      idle;
      rst0_n = 0; rst1_n = 0;
      tick; tick;
      tests++; if (id0 !== 0 || id1 !== 0) begin fails++; $display("FAIL reset_init_done got %b/%b want 0/0", id0, id1); end
      tests++; if (rva0 !== 0 || rvb0 !== 0 || rva1 !== 0 || rvb1 !== 0) begin fails++; $display("FAIL reset_valid got %b%b%b%b want 0000", rva0, rvb0, rva1, rvb1); end
      tests++; if (rda0 !== 0 || rdb0 !== 0 || rda1 !== 0 || rdb1 !== 0) begin fails++; $display("FAIL reset_data got %h %h %h %h want 00", rda0, rdb0, rda1, rdb1); end
      tests++; if (col0 !== 0 || col1 !== 0 || cnt0 !== 0 || cnt1 !== 0) begin fails++; $display("FAIL reset_collision got %b %b %0d %0d want 0", col0, col1, cnt0, cnt1); end
   endtask
   task automatic test_clear;
      rea = 1; raa = 2; wea = 1; waa = 2; wda = 8'hFF;
      rst0_n = 1;
      for (int k = 1; k <= 16; k++) begin
         tick;
         if (k == 4) rst1_n = 1;
         tests++; if (id0 !== (k == 16) || id1 !== (k == 16)) begin fails++; $display("FAIL clear_init_done edge %0d got %b/%b want %b", k, id0, id1, k == 16); end
         tests++; if (rva0 !== 0 || rva1 !== 0) begin fails++; $display("FAIL clear_no_valid edge %0d got %b/%b want 0", k, rva0, rva1); end
      end
      idle;
      for (int i = 0; i < 16; i++) begin
         rea = 1; raa = 4'(i);
         tick;
         tests++; if (rva0 !== 1 || rda0 !== 8'h00) begin fails++; $display("FAIL clear_read0 addr %0d got v=%b d=%h want v=1 d=00", i, rva0, rda0); end
         tests++; if (rva1 !== (i >= 1) || rda1 !== 8'h00) begin fails++; $display("FAIL clear_read1 addr %0d got v=%b d=%h want v=%b d=00", i, rva1, rda1, i >= 1); end
      end
      idle; tick; tick;
   endtask
   task automatic test_basic;
      logic [7:0] exp [4];
      wea = 1; waa = 3; wda = 8'h5A;
      tick;
      idle; reb = 1; rab = 3;
      tick;
      tests++; if (rvb0 !== 1 || rdb0 !== 8'h5A) begin fails++; $display("FAIL basic_lat1 got v=%b d=%h want v=1 d=5a", rvb0, rdb0); end
      tests++; if (rvb1 !== 0) begin fails++; $display("FAIL basic_lat2_early got v=%b want 0", rvb1); end
      idle;
      tick;
      tests++; if (rvb1 !== 1 || rdb1 !== 8'h5A) begin fails++; $display("FAIL basic_lat2 got v=%b d=%h want v=1 d=5a", rvb1, rdb1); end
      tests++; if (rvb0 !== 0 || rdb0 !== 8'h5A) begin fails++; $display("FAIL basic_hold got v=%b d=%h want v=0 d=5a", rvb0, rdb0); end
      tick;
      exp[0] = 8'h5A; exp[1] = 8'h00; exp[2] = 8'h5A; exp[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         reb = 1; rab = (i % 2 == 0) ? 4'd3 : 4'd0;
         tick;
         tests++; if (rvb0 !== 1 || rdb0 !== exp[i]) begin fails++; $display("FAIL b2b_lat1 %0d got v=%b d=%h want v=1 d=%h", i, rvb0, rdb0, exp[i]); end
         tests++; if (rvb1 !== (i >= 1) || (i >= 1 && rdb1 !== exp[(i + 3) % 4])) begin fails++; $display("FAIL b2b_lat2 %0d got v=%b d=%h", i, rvb1, rdb1); end
      end
      idle;
      tick;
      tests++; if (rvb0 !== 0 || rvb1 !== 1 || rdb1 !== exp[3]) begin fails++; $display("FAIL b2b_tail got v0=%b v1=%b d1=%h want 0 1 00", rvb0, rvb1, rdb1); end
      tick;
      tests++; if (rvb1 !== 0) begin fails++; $display("FAIL b2b_end got v1=%b want 0", rvb1); end
   endtask
   task automatic test_collision;
      wea = 1; web = 1; waa = 7; wab = 7; wda = 8'h11; wdb = 8'h22;
      tick;
      idle;
      tests++; if (col0 !== 1 || col1 !== 1 || cnt0 !== 1 || cnt1 !== 1) begin fails++; $display("FAIL coll_pulse got %b %b %0d %0d want 1 1 1 1", col0, col1, cnt0, cnt1); end
      rea = 1; raa = 7;
      tick;
      rea = 0;
      tests++; if (col0 !== 0 || col1 !== 0) begin fails++; $display("FAIL coll_one_cycle got %b %b want 0 0", col0, col1); end
      tests++; if (rda0 !== 8'h11) begin fails++; $display("FAIL coll_prio_a got %h want 11", rda0); end
      tick;
      tests++; if (rda1 !== 8'h22) begin fails++; $display("FAIL coll_prio_b got %h want 22", rda1); end
      wea = 1; web = 1; waa = 1; wab = 2; wda = 8'h31; wdb = 8'h32;
      tick;
      idle;
      tests++; if (col0 !== 0 || col1 !== 0 || cnt0 !== 1 || cnt1 !== 1) begin fails++; $display("FAIL nocoll got %b %b %0d %0d want 0 0 1 1", col0, col1, cnt0, cnt1); end
      rea = 1; raa = 1; reb = 1; rab = 2;
      tick;
      idle;
      tests++; if (rda0 !== 8'h31 || rdb0 !== 8'h32) begin fails++; $display("FAIL nocoll_data0 got %h %h want 31 32", rda0, rdb0); end
      tick;
      tests++; if (rda1 !== 8'h31 || rdb1 !== 8'h32) begin fails++; $display("FAIL nocoll_data1 got %h %h want 31 32", rda1, rdb1); end
   endtask
   task automatic test_rdw;
      wea = 1; waa = 5; wda = 8'hAA;
      tick;
      wda = 8'hBB; rea = 1; raa = 5;
      tick;
      wea = 0;
      tests++; if (rda0 !== 8'hAA) begin fails++; $display("FAIL rdw_old got %h want aa", rda0); end
      tick;
      rea = 0;
      tests++; if (rda0 !== 8'hBB) begin fails++; $display("FAIL rdw_after0 got %h want bb", rda0); end
      tests++; if (rva1 !== 1 || rda1 !== 8'hBB) begin fails++; $display("FAIL rdw_new got v=%b d=%h want 1 bb", rva1, rda1); end
      tick;
      tests++; if (rda1 !== 8'hBB) begin fails++; $display("FAIL rdw_after1 got %h want bb", rda1); end
      wea = 1; web = 1; waa = 6; wab = 6; wda = 8'hC1; wdb = 8'hC2; reb = 1; rab = 6;
      tick;
      idle;
      tick;
      tests++; if (rdb1 !== 8'hC2) begin fails++; $display("FAIL rdw_winner got %h want c2", rdb1); end
   endtask
   task automatic test_saturation;
      for (int i = 1; i <= 5; i++) begin
         wea = 1; web = 1; waa = 8; wab = 8; wda = 8'(8'h40 + i); wdb = 8'(8'h50 + i);
         tick;
         tests++; if (col0 !== 1 || col1 !== 1) begin fails++; $display("FAIL sat_pulse %0d got %b %b want 1 1", i, col0, col1); end
         tests++; if (cnt0 !== 8'(2 + i) || cnt1 !== ((2 + i) > 3 ? 2'd3 : 2'(2 + i))) begin fails++; $display("FAIL sat_cnt %0d got %0d %0d", i, cnt0, cnt1); end
      end
      idle;
      tick;
      tests++; if (col0 !== 0 || cnt0 !== 7 || cnt1 !== 3) begin fails++; $display("FAIL sat_final got %b %0d %0d want 0 7 3", col0, cnt0, cnt1); end
      wea = 1; web = 1; waa = 13; wab = 13; wda = 8'h77; wdb = 8'h78;
      tick;
      idle;
      tests++; if (col0 !== 1 || col1 !== 0 || cnt0 !== 8 || cnt1 !== 3) begin fails++; $display("FAIL range_coll got %b %b %0d %0d want 1 0 8 3", col0, col1, cnt0, cnt1); end
      rea = 1; raa = 13;
      tick;
      idle;
      tests++; if (rva0 !== 1 || rda0 !== 8'h77) begin fails++; $display("FAIL range_in got v=%b d=%h want 1 77", rva0, rda0); end
      tick;
      tests++; if (rva1 !== 1 || rda1 !== 8'h00) begin fails++; $display("FAIL range_out got v=%b d=%h want 1 00", rva1, rda1); end
   endtask
   task automatic test_mid_clear;
      rst0_n = 0; rst1_n = 0;
      #1;
      tests++; if (id0 !== 0 || rda0 !== 0 || cnt0 !== 0 || cnt1 !== 0) begin fails++; $display("FAIL mid_reset got %b %h %0d %0d want 0", id0, rda0, cnt0, cnt1); end
      tick;
      rst0_n = 1; rst1_n = 1;
      for (int k = 0; k < 8; k++) tick;
      rst0_n = 0; rst1_n = 0;
      tick;
      rst0_n = 1; rst1_n = 1;
      for (int k = 1; k <= 16; k++) begin
         tick;
         tests++; if (id0 !== (k >= 16) || id1 !== (k >= 12)) begin fails++; $display("FAIL mid_init_done edge %0d got %b/%b", k, id0, id1); end
      end
      rea = 1; raa = 3; reb = 1; rab = 7;
      tick;
      idle;
      tests++; if (rva0 !== 1 || rda0 !== 0 || rvb0 !== 1 || rdb0 !== 0) begin fails++; $display("FAIL mid_data0 got %b %h %b %h want 1 00 1 00", rva0, rda0, rvb0, rdb0); end
      tick;
      tests++; if (rva1 !== 1 || rda1 !== 0 || rvb1 !== 1 || rdb1 !== 0) begin fails++; $display("FAIL mid_data1 got %b %h %b %h want 1 00 1 00", rva1, rda1, rvb1, rdb1); end
   endtask
   initial begin
      test_reset;
      test_clear;
      test_basic;
      test_collision;
      test_rdw;
      test_saturation;
      test_mid_clear;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
